alu_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU: a WIDTH-bit arithmetic unit with a registered valid/ready issue interface, plus an iterative multiply/divide engine writing architectural HI/LO registers. Sits in the EX stage of the MIPS datapath. Simple ops complete in one cycle; MULT/DIV stall the pipeline through `in_ready`.

---
 rtl/alu_mdu_pkg.sv | 32 +++
 rtl/alu_mdu_iter.sv | 111 +++++++++++
 rtl/alu_mdu.sv | 159 +++++++++++++++
 tb/tb_alu_mdu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared opcodes, FSM states and default width for the alu_mdu EX-stage unit.
// ALU_MDU_DIV_EN adds the DIV state to the FSM encoding.
package alu_mdu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_LUI   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_MDU_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_MUL  = 2'd1
    } state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative shift-register datapath shared by multiply and divide: one bit per cycle
// on operand magnitudes, sign fix-up applied to the final step. Divider built only with ALU_MDU_DIV_EN.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             start_div,
    input  logic             start_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             run_mul,
    input  logic             run_div,
    output logic             last,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic [WIDTH-1:0]   quo, rem;

`ifdef ALU_MDU_DIV_EN
    logic [WIDTH:0]     div_tmp, div_diff;
    logic               div_ge;

    // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opnd_q};
        div_ge   = (div_tmp >= {1'b0, opnd_q});
        div_step = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};
    end
`else
    assign div_step = '0;
`endif

    always_comb begin
        a_neg    = start_signed && a[WIDTH-1];
        b_neg    = start_signed && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        if (start) begin
            acc_d     = {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
            opnd_d    = start_div ? b_mag : a_mag;
            cnt_d     = '0;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = start_div && (b == '0);
        end else if (run_mul || run_div) begin
            acc_d = run_div ? div_step : mul_step;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Results are taken from the final step's next value so they land with the last edge.
    always_comb begin
        last = (run_mul || run_div) && (cnt_q == CNT_W'(WIDTH - 1));
        prod = neg_q ? -acc_d : acc_d;
        quo  = acc_d[WIDTH-1:0];
        rem  = acc_d[2*WIDTH-1:WIDTH];
        if (run_div) begin
            hi_res = rem_neg_q ? -rem : rem;
            lo_res = dz_q ? '1 : (neg_q ? -quo : quo);
        end else begin
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opnd_q    <= opnd_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
        dz_q      <= dz_d;
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with valid/ready issue and an iterative MULT/DIV engine writing HI/LO.
// ALU_MDU_DIV_EN builds DIV/DIVU; otherwise they retire in one cycle with a zero result.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic                    accept;
    logic                    mdu_start, mdu_div, mdu_signed;
    logic                    run_mul, run_div, mdu_last;
    logic [WIDTH-1:0]        mdu_hi, mdu_lo;
    logic [WIDTH-1:0]        simple_res;
    logic signed [WIDTH-1:0] a_s, b_s, sra_res;

    assign a_s     = A;
    assign b_s     = B;
    assign sra_res = b_s >>> shamt;
    assign accept  = in_valid && (state_q == ST_IDLE);
    assign run_mul = (state_q == ST_MUL);
`ifdef ALU_MDU_DIV_EN
    assign run_div = (state_q == ST_DIV);
`else
    assign run_div = 1'b0;
`endif

    always_comb begin
        simple_res = '0;
        case (ALUOperation)
            OP_AND:  simple_res = A & B;
            OP_OR:   simple_res = A | B;
            OP_NOR:  simple_res = ~(A | B);
            OP_ADD:  simple_res = A + B;
            OP_SUB:  simple_res = A - B;
            OP_SLL:  simple_res = B << shamt;
            OP_SRL:  simple_res = B >> shamt;
            OP_LUI:  simple_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SRA:  simple_res = $unsigned(sra_res);
            OP_MFHI: simple_res = hi_q;
            OP_MFLO: simple_res = lo_q;
            default: simple_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mdu_start   = 1'b0;
        mdu_div     = 1'b0;
        mdu_signed  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (ALUOperation)
                        OP_MULT, OP_MULTU: begin
                            mdu_start  = 1'b1;
                            mdu_signed = (ALUOperation == OP_MULT);
                            state_d    = ST_MUL;
                        end
`ifdef ALU_MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            mdu_start  = 1'b1;
                            mdu_div    = 1'b1;
                            mdu_signed = (ALUOperation == OP_DIV);
                            state_d    = ST_DIV;
                        end
`endif
                        default: begin
                            out_valid_d = 1'b1;
                            result_d    = simple_res;
                            zero_d      = (simple_res == '0);
                        end
                    endcase
                end
            end
            default: begin
                if (mdu_last) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    hi_d        = mdu_hi;
                    lo_d        = mdu_lo;
                    result_d    = mdu_lo;
                    zero_d      = (mdu_lo == '0);
                end
            end
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .start        (mdu_start),
        .start_div    (mdu_div),
        .start_signed (mdu_signed),
        .a            (A),
        .b            (B),
        .run_mul      (run_mul),
        .run_div      (run_div),
        .last         (mdu_last),
        .hi_res       (mdu_hi),
        .lo_res       (mdu_lo)
    );

    // Reset aborts any iteration in flight and clears the architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32); DIV checks follow whether ALU_MDU_DIV_EN is defined.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUOperation = 4'd0;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOperation(ALUOperation), .A(A), .B(B), .shamt(shamt),
        .out_valid(out_valid), .ALUResult(ALUResult), .Zero(Zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        ALUOperation = op; A = a; B = b; shamt = sh; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (ALUResult !== 32'h0) begin n_err++; $display("FAIL reset ALUResult: got %h want 0", ALUResult); end
        n_vec++; if (Zero !== 1'b0) begin n_err++; $display("FAIL reset Zero: got %b want 0", Zero); end
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL reset hilo: got %h/%h want 0/0", hi, lo); end
    endtask

    task automatic test_add_sub();
        drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_err++; $display("FAIL add_wrap: got v=%b r=%h z=%b want v=1 r=0 z=1", out_valid, ALUResult, Zero); end
        drive(OP_SUB, 32'd5, 32'd5, 5'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            n_err++; $display("FAIL sub_zero: got v=%b r=%h z=%b want v=1 r=0 z=1", out_valid, ALUResult, Zero); end
        drive(OP_ADD, 32'd2, 32'd3, 5'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'd5 || Zero !== 1'b0) begin
            n_err++; $display("FAIL add_small: got v=%b r=%h z=%b want v=1 r=5 z=0", out_valid, ALUResult, Zero); end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || ALUResult !== 32'd5) begin
            n_err++; $display("FAIL hold: got v=%b r=%h want v=0 r=5", out_valid, ALUResult); end
    endtask

    task automatic test_simple_ops();
        logic [3:0]  ops [10];
        logic [31:0] as  [10];
        logic [31:0] bs  [10];
        logic [4:0]  shs [10];
        logic [31:0] exp [10];
        ops[0] = OP_SRA; as[0] = 32'h0;         bs[0] = 32'h8000_0000; shs[0] = 5'd4;  exp[0] = 32'hF800_0000;
        ops[1] = OP_SLT; as[1] = 32'hFFFF_FFFF; bs[1] = 32'h1;         shs[1] = 5'd0;  exp[1] = 32'h1;
        ops[2] = OP_LUI; as[2] = 32'h0;         bs[2] = 32'h0000_1234; shs[2] = 5'd0;  exp[2] = 32'h1234_0000;
        ops[3] = OP_AND; as[3] = 32'hF0F0_F0F0; bs[3] = 32'hFF00_FF00; shs[3] = 5'd0;  exp[3] = 32'hF000_F000;
        ops[4] = OP_OR;  as[4] = 32'hF0F0_F0F0; bs[4] = 32'h0F0F_0000; shs[4] = 5'd0;  exp[4] = 32'hFFFF_F0F0;
        ops[5] = OP_NOR; as[5] = 32'hF0F0_F0F0; bs[5] = 32'h0F0F_0000; shs[5] = 5'd0;  exp[5] = 32'h0000_0F0F;
        ops[6] = OP_SLL; as[6] = 32'h0;         bs[6] = 32'h0000_0003; shs[6] = 5'd31; exp[6] = 32'h8000_0000;
        ops[7] = OP_SRL; as[7] = 32'h0;         bs[7] = 32'h8000_0000; shs[7] = 5'd31; exp[7] = 32'h0000_0001;
        ops[8] = OP_SLT; as[8] = 32'h1;         bs[8] = 32'hFFFF_FFFF; shs[8] = 5'd0;  exp[8] = 32'h0;
        ops[9] = OP_SRA; as[9] = 32'h0;         bs[9] = 32'h7FFF_FFF0; shs[9] = 5'd4;  exp[9] = 32'h07FF_FFFF;
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], as[i], bs[i], shs[i]);
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1 || ALUResult !== exp[i] || Zero !== (exp[i] == 32'h0)) begin
                n_err++; $display("FAIL simple_op[%0d]: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                                  i, out_valid, ALUResult, Zero, exp[i], (exp[i] == 32'h0)); end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat;
        drive(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd1, 5'd0);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mult busy in_ready: got %b want 0", in_ready); end
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mult latency: got %0d want 33", lat); end
        n_vec++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || ALUResult !== 32'hFFFF_FFEB) begin
            n_err++; $display("FAIL mult result: got hi=%h lo=%h r=%h want FFFFFFFF/FFFFFFEB/FFFFFFEB", hi, lo, ALUResult); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mult done in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'd2) begin
            n_err++; $display("FAIL issue_at_completion: got v=%b r=%h want v=1 r=2", out_valid, ALUResult); end
        @(negedge clk);
    endtask

    task automatic test_mfhi_completion();
        int lat;
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
        @(negedge clk);
        drive(OP_MFHI, 32'h0, 32'h0, 5'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        n_vec++; if (lat !== 33 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL multu: got lat=%0d hi=%h lo=%h want 33/1/FFFFFFFE", lat, hi, lo); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'h1) begin
            n_err++; $display("FAIL mfhi_completion: got v=%b r=%h want v=1 r=1", out_valid, ALUResult); end
        drive(OP_MFLO, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (ALUResult !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL mflo: got %h want FFFFFFFE", ALUResult); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mult();
        int pulses;
        drive(OP_MULT, 32'd5, 32'd6, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort in_ready: got %b want 1", in_ready); end
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0 || ALUResult !== 32'h0) begin
            n_err++; $display("FAIL abort clear: got hi=%h lo=%h r=%h want 0/0/0", hi, lo, ALUResult); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort out_valid: got %0d pulses want 0", pulses); end
    endtask

`ifdef ALU_MDU_DIV_EN
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        drive(op, a, b, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic test_div();
        int lat;
        run_mdu(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        n_vec++; if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || ALUResult !== 32'hFFFF_FFFD) begin
            n_err++; $display("FAIL div_neg: got lat=%0d hi=%h lo=%h want 33/FFFFFFFF/FFFFFFFD", lat, hi, lo); end
        run_mdu(OP_DIVU, 32'd7, 32'd0, lat);
        n_vec++; if (lat !== 33 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h want 33/7/FFFFFFFF", lat, hi, lo); end
        run_mdu(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        n_vec++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            n_err++; $display("FAIL div_min_neg1: got hi=%h lo=%h want 0/80000000", hi, lo); end
        run_mdu(OP_DIV, 32'hFFFF_FFF8, 32'd0, lat);
        n_vec++; if (hi !== 32'hFFFF_FFF8 || lo !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL div_signed_by_zero: got hi=%h lo=%h want FFFFFFF8/FFFFFFFF", hi, lo); end
        run_mdu(OP_DIVU, 32'd100, 32'd7, lat);
        n_vec++; if (hi !== 32'd2 || lo !== 32'd14) begin
            n_err++; $display("FAIL divu: got hi=%h lo=%h want 2/E", hi, lo); end
        @(negedge clk);
    endtask
`else
    task automatic test_div_disabled();
        drive(OP_DIV, 32'd7, 32'd2, 5'd0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL div_off: got v=%b r=%h z=%b rdy=%b want 1/0/1/1", out_valid, ALUResult, Zero, in_ready); end
        n_vec++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL div_off hilo: got %h/%h want 1/FFFFFFFE", hi, lo); end
        drive(OP_ADD, 32'd4, 32'd4, 5'd0);
        @(negedge clk);
        drive(OP_DIVU, 32'd7, 32'd0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1 || hi !== 32'h1) begin
            n_err++; $display("FAIL divu_off: got v=%b r=%h z=%b hi=%h want 1/0/1/1", out_valid, ALUResult, Zero, hi); end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_simple_ops();
        test_mult();
        test_mfhi_completion();
`ifndef ALU_MDU_DIV_EN
        test_div_disabled();
`endif
        test_reset_mid_mult();
`ifdef ALU_MDU_DIV_EN
        test_div();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
